alu_issue_queue: RTL and testbench

Request buffer that sits directly upstream of the `alu` block. It accepts operation requests (a, b, cin, ctl) over a valid/ready handshake and holds them in a small FIFO. It issues them to the ALU as single-cycle `valid_in` pulses with registered operands. Requests carrying an unsupported opcode are rejected at enqueue and never reach the ALU.

---
 rtl/alu_issue_queue.sv | 145 ++++++++++++++
 tb/tb_alu_issue_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Request FIFO feeding the ALU with single-cycle valid_in pulses and
//            registered operands; opcodes 14/15 are rejected at enqueue.
//            Optional macro ALU_IQ_BYPASS_EN adds an empty-queue bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic                     req_cin,
  input  logic [3:0]               req_ctl,
  input  logic                     issue_en,
  output logic                     valid_in,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic                     cin,
  output logic [3:0]               ctl,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     req_err,
  output logic [7:0]               err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * WIDTH + 5;

  localparam logic [CW-1:0] C_FULL          = CW'(DEPTH);
  localparam logic [CW-1:0] C_CNT_ONE       = CW'(1);
  localparam logic [PW-1:0] C_PTR_ONE       = PW'(1);
  localparam logic [3:0]    C_FIRST_ILLEGAL = 4'd14;
  localparam logic [7:0]    C_ERR_MAX       = 8'hFF;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          w_accept;
  logic          w_illegal;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass;
  logic          w_write;
  logic [EW-1:0] w_req_entry;

  assign req_ready   = (count_q != C_FULL);
  assign w_accept    = req_valid && req_ready;
  assign w_illegal   = (req_ctl >= C_FIRST_ILLEGAL);
  assign w_push      = w_accept && !w_illegal;
  assign w_pop       = issue_en && (count_q != '0);
  assign w_req_entry = {req_a, req_b, req_cin, req_ctl};

`ifdef ALU_IQ_BYPASS_EN
  // An empty queue with issue enabled hands the request straight to the output register.
  assign w_bypass = w_push && (count_q == '0) && issue_en;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_write = w_push && !w_bypass;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    err_d     = w_accept && w_illegal;
    err_cnt_d = err_cnt_q;

    if (w_write) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end

    case ({w_write, w_pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    // Pop and bypass are exclusive: bypass needs an empty queue, pop a non-empty one.
    if (w_pop) begin
      out_d   = mem_q[rd_ptr_q];
      valid_d = 1'b1;
    end else if (w_bypass) begin
      out_d   = w_req_entry;
      valid_d = 1'b1;
    end

    if (err_d && (err_cnt_q != C_ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && w_write) begin
      mem_q[wr_ptr_q] <= w_req_entry;
    end
  end

  assign valid_in         = valid_q;
  assign {a, b, cin, ctl} = out_q;
  assign count            = count_q;
  assign req_err          = err_q;
  assign err_count        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_queue
// Purpose  : Self-checking bench for alu_issue_queue against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int VW    = 1 + 2 * WIDTH + 1 + 4 + CW + 1 + 1 + 8;
`ifdef ALU_IQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       ctl;
  } ent_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a, req_b;
  logic             req_cin;
  logic [3:0]       req_ctl;
  logic             issue_en;
  logic             valid_in;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [3:0]       ctl;
  logic [CW-1:0]    count;
  logic             req_err;
  logic [7:0]       err_count;

  alu_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctl(req_ctl),
    .issue_en(issue_en), .valid_in(valid_in), .a(a), .b(b), .cin(cin),
    .ctl(ctl), .count(count), .req_err(req_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t mq[$];
  logic ev;
  ent_t eo;
  logic eerr;
  int   ecnt;
  bit   last_hs;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [VW-1:0] obs_vec();
    return {valid_in, a, b, cin, ctl, count, req_ready, req_err, err_count};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {ev, eo, CW'(mq.size()), (mq.size() != DEPTH), eerr, 8'(ecnt)};
  endfunction

  function automatic ent_t rand_legal();
    ent_t r;
    r.a   = WIDTH'($urandom);
    r.b   = WIDTH'($urandom);
    r.cin = 1'($urandom);
    r.ctl = 4'($urandom_range(0, 13));
    return r;
  endfunction

  task automatic drive(input bit v, input ent_t r);
    req_valid = v;
    req_a     = r.a;
    req_b     = r.b;
    req_cin   = r.cin;
    req_ctl   = r.ctl;
  endtask

  // Advance the model by one edge using the inputs currently driven, then step the DUT.
  task automatic tick();
    ent_t r;
    bit   hs, ill, pop, byp;
    if (!reset) begin
      mq.delete();
      ev = 1'b0; eo = '0; eerr = 1'b0; ecnt = 0; last_hs = 1'b0;
    end else begin
      hs  = req_valid && (mq.size() < DEPTH);
      ill = (req_ctl >= 4'd14);
      pop = issue_en && (mq.size() > 0);
      byp = 1'b0;
`ifdef ALU_IQ_BYPASS_EN
      byp = hs && !ill && (mq.size() == 0) && issue_en;
`endif
      r = '{req_a, req_b, req_cin, req_ctl};
      if (pop) begin
        eo = mq.pop_front(); ev = 1'b1;
      end else if (byp) begin
        eo = r; ev = 1'b1;
      end else begin
        ev = 1'b0;
      end
      if (hs && !ill && !byp) mq.push_back(r);
      eerr = hs && ill;
      if (eerr && ecnt < 255) ecnt++;
      last_hs = hs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rst_vec;
    reset = 1'b0; issue_en = 1'b0; drive(1'b0, '0);
    tick(); tick();
    reset = 1'b1;
    rst_vec = {1'b0, {(2*WIDTH+5){1'b0}}, {CW{1'b0}}, 1'b1, 1'b0, 8'd0};
    n_checks++;
    if (obs_vec() !== rst_vec) $display("FAIL reset_state: got %h expected %h", obs_vec(), rst_vec);
    else n_pass++;
  endtask

  task automatic test_single();
    int   pulses = 0, pulse_at = -1;
    ent_t cap = '0;
    issue_en = 1'b1;
    drive(1'b1, '{4'h3, 4'h5, 1'b0, 4'd3});
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b0, '0);
      if (valid_in) begin pulses++; pulse_at = i; cap = '{a, b, cin, ctl}; end
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL single cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses !== 1 || pulse_at !== LAT) $display("FAIL single_latency: got %0d pulses at %0d expected 1 at %0d", pulses, pulse_at, LAT);
    else n_pass++;
    n_checks++;
    if (cap !== ent_t'({4'h3, 4'h5, 1'b0, 4'd3}) || count !== '0) $display("FAIL single_data: got %h cnt %0d expected 3503 cnt 0", cap, count);
    else n_pass++;
  endtask

  task automatic test_fill();
    ent_t reqs[5];
    ent_t got[$];
    int   k = 0;
    foreach (reqs[i]) reqs[i] = rand_legal();
    issue_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, reqs[k]);
      tick();
      if (last_hs) k++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL fill cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (req_ready !== 1'b0 || count !== CW'(4) || k !== 4) $display("FAIL fill_full: got ready %b cnt %0d acc %0d expected 0 4 4", req_ready, count, k);
    else n_pass++;
    issue_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (k < 5) drive(1'b1, reqs[k]); else drive(1'b0, '0);
      tick();
      if (last_hs) k++;
      if (valid_in) got.push_back('{a, b, cin, ctl});
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL drain cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (got.size() !== 5) $display("FAIL drain_pulses: got %0d expected 5", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got[i] !== reqs[i]) $display("FAIL drain_order%0d: got %h expected %h", i, got[i], reqs[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    ent_t seq[3];
    int   errs = 0, pulses = 0;
    ent_t cap = '0;
    seq[0] = '{4'h1, 4'h2, 1'b0, 4'd14};
    seq[1] = '{4'h3, 4'h4, 1'b1, 4'd15};
    seq[2] = '{4'h7, 4'hA, 1'b0, 4'd0};
    issue_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) drive(1'b1, seq[i]); else drive(1'b0, '0);
      tick();
      if (req_err) errs++;
      if (valid_in) begin pulses++; cap = '{a, b, cin, ctl}; end
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL illegal cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (errs !== 2 || err_count !== 8'd2) $display("FAIL illegal_err: got %0d pulses cnt %0d expected 2 2", errs, err_count);
    else n_pass++;
    n_checks++;
    if (pulses !== 1 || cap.ctl !== 4'd0 || cap.b !== 4'hA) $display("FAIL illegal_issue: got %0d pulses ctl %h b %h expected 1 0 a", pulses, cap.ctl, cap.b);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    ent_t reqs[10];
    ent_t got[$];
    int   k = 0;
    foreach (reqs[i]) reqs[i] = rand_legal();
    issue_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (k < 10) drive(1'b1, reqs[k]); else drive(1'b0, '0);
      tick();
      if (last_hs) k++;
      if (valid_in) got.push_back('{a, b, cin, ctl});
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL stream cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i >= 2 && i < 10) begin
        n_checks++;
        if (count !== CW'(LAT) || valid_in !== 1'b1) $display("FAIL stream_steady cyc%0d: got cnt %0d v %b expected %0d 1", i, count, valid_in, LAT);
        else n_pass++;
      end
    end
    n_checks++;
    if (got.size() !== 10) $display("FAIL stream_pulses: got %0d expected 10", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (got[i] !== reqs[i]) $display("FAIL stream_order%0d: got %h expected %h", i, got[i], reqs[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    ent_t r;
    for (int i = 0; i < 300; i++) begin
      if (!req_valid || last_hs) begin
        r     = rand_legal();
        r.ctl = 4'($urandom_range(0, 15));
        drive(($urandom_range(0, 99) < 60), r);
      end
      issue_en = ($urandom_range(0, 99) < 65);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    drive(1'b0, '0);
  endtask

  task automatic test_reset_mid();
    int   pulses = 0;
    ent_t r;
    reset = 1'b0; tick(); reset = 1'b1;
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = rand_legal();
      drive(1'b1, r);
      tick();
    end
    drive(1'b0, '0);
    n_checks++;
    if (count !== CW'(3)) $display("FAIL rstmid_fill: got %0d expected 3", count);
    else n_pass++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if (count !== '0 || valid_in !== 1'b0 || err_count !== 8'd0 || req_ready !== 1'b1) $display("FAIL rstmid_state: got cnt %0d v %b err %0d rdy %b expected 0 0 0 1", count, valid_in, err_count, req_ready);
    else n_pass++;
    issue_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_in) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL rstmid_stale: got %0d pulses expected 0", pulses);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int   pulses = 0;
    ent_t r;
    issue_en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      r     = rand_legal();
      r.ctl = 4'($urandom_range(14, 15));
      drive(1'b1, r);
      tick();
      if (valid_in) pulses++;
      if (i % 20 == 0 || i > 250) begin
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL sat cyc%0d: got %h expected %h", i, obs_vec(), exp_vec());
        else n_pass++;
      end
    end
    drive(1'b0, '0);
    n_checks++;
    if (err_count !== 8'd255 || pulses !== 0) $display("FAIL sat_final: got cnt %0d pulses %0d expected 255 0", err_count, pulses);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; issue_en = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; req_ctl = '0;
    last_hs = 1'b0; ev = 1'b0; eo = '0; eerr = 1'b0; ecnt = 0;
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
